// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit: FSM state
// encoding, instruction field constants and datapath select encodings.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERR    = 3'd7
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct field (IR[5:0])
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // PC source select
  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  // Register file destination select
  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  // Register file write-data select
  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC4 = 2'b10;

  // ALU operation select
  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUB   = 3'b001;
  localparam logic [2:0] ALU_OP_FUNCT = 3'b010;

  // Opcodes that continue from DECODE into EXEC
  function automatic logic is_exec_op(input logic [5:0] op);
    logic r;
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: r = 1'b1;
      default:                                         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_ctrl_watchdog.sv
// Memory-wait watchdog. Counts consecutive wait cycles and flags expiry on
// the cycle that would reach TIMEOUT, so the FSM leaves on the next edge.
// A ready cycle never counts as a wait, so a late ready always wins.
// TIMEOUT = 0 disables the watchdog entirely.
module mc_ctrl_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic waiting_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic WD_EN = (TIMEOUT != 0);

  logic [CW-1:0] r_count;

  // Wait-cycle counter: cleared on state entry or reset, advances while waiting
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_count <= '0;
    end else if (waiting_i && WD_EN) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign expired_o = WD_EN && waiting_i && (r_count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM. Control outputs are decoded
// combinationally from the current state and instruction fields.
// Optional feature: define MULTICYCLE_CTRL_PERF_EN to add retired_cnt_o,
// a wrapping count of completed instructions.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       ir_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [2:0] state_o,
  output logic       err_o
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] retired_cnt_o
`endif
);

  state_e     r_state;
  state_e     w_state_next;
  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_ir_write;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;
  logic       w_alu_src_b;
  logic [2:0] w_alu_op;
  logic       w_is_jr;
  logic       w_waiting;
  logic       w_wd_clear;
  logic       w_expired;

  assign w_is_jr = (instr_op_i == OP_RTYPE) && (funct_i == FUNCT_JR);

  // Watchdog counts only memory-wait cycles and restarts on every state entry
  assign w_waiting  = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready_i;
  assign w_wd_clear = rst_i || (w_state_next != r_state);

  mc_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .clear_i   (w_wd_clear),
    .waiting_i (w_waiting),
    .expired_o (w_expired)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_next = r_state;
    w_pc_write   = 1'b0;
    w_pc_src     = PC_SRC_PC4;
    w_ir_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = REG_DST_RT;
    w_mem_to_reg = MEM_TO_REG_ALU;
    w_alu_src_b  = 1'b0;
    w_alu_op     = ALU_OP_ADD;

    case (r_state)
      ST_FETCH: begin
        w_mem_read = 1'b1;
        if (mem_ready_i) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_state_next = ST_DECODE;
        end else if (w_expired) begin
          w_state_next = ST_ERR;
        end else begin
          w_state_next = ST_FETCH;
        end
      end

      ST_DECODE: begin
        if (instr_op_i == OP_J) begin
          w_pc_write   = 1'b1;
          w_pc_src     = PC_SRC_JUMP;
          w_state_next = ST_FETCH;
        end else if (instr_op_i == OP_JAL) begin
          w_pc_write   = 1'b1;
          w_pc_src     = PC_SRC_JUMP;
          w_reg_write  = 1'b1;
          w_reg_dst    = REG_DST_R31;
          w_mem_to_reg = MEM_TO_REG_PC4;
          w_state_next = ST_FETCH;
        end else if (w_is_jr) begin
          w_pc_write   = 1'b1;
          w_pc_src     = PC_SRC_RS;
          w_state_next = ST_FETCH;
        end else if (is_exec_op(instr_op_i)) begin
          w_state_next = ST_EXEC;
        end else begin
          w_state_next = ST_ERR;
        end
      end

      ST_EXEC: begin
        case (instr_op_i)
          OP_RTYPE: begin
            w_alu_op     = ALU_OP_FUNCT;
            w_state_next = ST_WB;
          end
          OP_ADDI: begin
            w_alu_op     = ALU_OP_ADD;
            w_alu_src_b  = 1'b1;
            w_state_next = ST_WB;
          end
          OP_LW, OP_SW: begin
            w_alu_op     = ALU_OP_ADD;
            w_alu_src_b  = 1'b1;
            w_state_next = ST_MEM;
          end
          OP_BEQ: begin
            w_alu_op     = ALU_OP_SUB;
            w_pc_src     = PC_SRC_BRANCH;
            w_pc_write   = zero_i;
            w_state_next = ST_FETCH;
          end
          OP_BNE: begin
            w_alu_op     = ALU_OP_SUB;
            w_pc_src     = PC_SRC_BRANCH;
            w_pc_write   = !zero_i;
            w_state_next = ST_FETCH;
          end
          default: begin
            w_state_next = ST_ERR;
          end
        endcase
      end

      ST_MEM: begin
        w_iord = 1'b1;
        if (instr_op_i == OP_LW) begin
          w_mem_read = 1'b1;
        end else if (instr_op_i == OP_SW) begin
          w_mem_write = 1'b1;
        end else begin
          w_mem_read = 1'b0;
        end
        if ((instr_op_i != OP_LW) && (instr_op_i != OP_SW)) begin
          w_state_next = ST_ERR;
        end else if (mem_ready_i) begin
          w_state_next = (instr_op_i == OP_LW) ? ST_WB : ST_FETCH;
        end else if (w_expired) begin
          w_state_next = ST_ERR;
        end else begin
          w_state_next = ST_MEM;
        end
      end

      ST_WB: begin
        w_reg_write  = 1'b1;
        w_state_next = ST_FETCH;
        case (instr_op_i)
          OP_RTYPE: w_reg_dst = REG_DST_RD;
          OP_ADDI:  w_reg_dst = REG_DST_RT;
          OP_LW:    w_mem_to_reg = MEM_TO_REG_MEM;
          default: begin
            w_reg_write  = 1'b0;
            w_state_next = ST_ERR;
          end
        endcase
      end

      ST_ERR: begin
        w_state_next = ST_ERR;
      end

      default: begin
        w_state_next = ST_ERR;
      end
    endcase
  end

  // Strobes are held low while reset is asserted
  assign pc_write_o   = w_pc_write  & ~rst_i;
  assign ir_write_o   = w_ir_write  & ~rst_i;
  assign mem_read_o   = w_mem_read  & ~rst_i;
  assign mem_write_o  = w_mem_write & ~rst_i;
  assign reg_write_o  = w_reg_write & ~rst_i;
  assign pc_src_o     = w_pc_src;
  assign iord_o       = w_iord;
  assign reg_dst_o    = w_reg_dst;
  assign mem_to_reg_o = w_mem_to_reg;
  assign alu_src_b_o  = w_alu_src_b;
  assign alu_op_o     = w_alu_op;
  assign state_o      = r_state;
  assign err_o        = (r_state == ST_ERR);

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic        w_retire;
  logic [31:0] r_retired;

  assign w_retire = (r_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) &&
                    (w_state_next == ST_FETCH);

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_retired <= 32'd0;
    end else if (w_retire) begin
      r_retired <= r_retired + 32'd1;
    end else begin
      r_retired <= r_retired;
    end
  end

  assign retired_cnt_o = r_retired;
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max wait cycles for mem_ready_i per FETCH/MEM visit (0 = watchdog disabled).
REQ-002 SHALL have ports:
- clk_i  in  1  single clock
- rst_i  in  1  reset, synchronous, active-high
- instr_op_i  in  6  opcode (IR[31:26])
- funct_i  in  6  funct (IR[5:0])
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory access complete this cycle
- pc_write_o  out  1  PC load
- pc_src_o  out  2  00 pc+4, 01 branch target, 10 jump target, 11 RS
- ir_write_o  out  1  instruction register load
- iord_o  out  1  memory address: 0 PC, 1 ALU result
- mem_read_o / mem_write_o  out  1 each  memory strobes
- reg_write_o  out  1  register file write
- reg_dst_o  out  2  00 rt, 01 rd, 10 r31
- mem_to_reg_o  out  2  00 ALU, 01 memory, 10 pc+4
- alu_src_b_o  out  1  0 RT data, 1 sign-extended imm
- alu_op_o  out  3  000 add, 001 sub, 010 use funct
- state_o  out  3  current state encoding
- err_o  out  1  sticky fault

Function
REQ-003 SHALL implement FSM FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), ERR(7); outputs combinational from state, opcode, funct, zero_i, mem_ready_i.
REQ-004 FETCH SHALL assert mem_read_o, iord_o=0; when mem_ready_i=1 assert ir_write_o, pc_write_o with pc_src_o=00 same cycle, next DECODE; else stay.
REQ-005 DECODE SHALL: j (000010) -> pc_write_o, pc_src_o=10, to FETCH; jal (000011) -> same plus reg_write_o, reg_dst_o=10, mem_to_reg_o=10; R-type with funct 001000 (jr) -> pc_write_o, pc_src_o=11, to FETCH; R, addi (001000), lw (100011), sw (101011), beq (000100), bne (000101) -> EXEC; any other opcode -> ERR.
REQ-006 EXEC SHALL: R -> alu_op_o=010, alu_src_b_o=0, to WB; addi -> alu_op_o=000, alu_src_b_o=1, to WB; lw/sw -> alu_op_o=000, alu_src_b_o=1, to MEM; beq/bne -> alu_op_o=001, alu_src_b_o=0, pc_src_o=01, pc_write_o=zero_i (beq) or !zero_i (bne), to FETCH.
REQ-007 MEM SHALL hold iord_o=1 and mem_read_o (lw) or mem_write_o (sw) until mem_ready_i=1; then lw -> WB, sw -> FETCH.
REQ-008 WB SHALL assert reg_write_o for one cycle: R reg_dst_o=01, mem_to_reg_o=00; addi reg_dst_o=00, mem_to_reg_o=00; lw reg_dst_o=00, mem_to_reg_o=01; then FETCH.
REQ-009 Latency with zero-wait memory SHALL be: j/jal/jr 2, beq/bne 3, R/addi/sw 4, lw 5 cycles.
REQ-010 Watchdog: wait counter SHALL clear on entering FETCH/MEM, increment each cycle mem_ready_i=0 there; reaching TIMEOUT SHALL move to ERR next cycle; mem_ready_i=1 on the TIMEOUT cycle SHALL win.
REQ-011 ERR SHALL deassert all strobes, set err_o=1, remain until rst_i.
REQ-012 At most one of mem_read_o, mem_write_o SHALL be high in any cycle; no strobe SHALL assert in ERR.

Reset
REQ-013 rst_i=1 at a clock edge SHALL force state FETCH, clear err_o, watchdog and counters, regardless of state (including mid-MEM wait).
REQ-014 While rst_i=1 all write/read strobes SHALL be forced 0; first fetch strobe SHALL appear the cycle after rst_i falls.

Configuration
REQ-015 Macro MULTICYCLE_CTRL_PERF_EN defined: port retired_cnt_o out 32 SHALL count instructions completed (transitions into FETCH from DECODE, EXEC, MEM or WB), reset 0, wrapping at 2^32; undefined: port and counter absent, behaviour otherwise identical.

Structure
REQ-016 Shared package cpu_ctrl_pkg SHALL hold state enum, opcode/funct constants, pc_src, reg_dst, mem_to_reg, alu_op encodings.
REQ-017 Watchdog SHALL be sub-module mc_ctrl_watchdog (inputs clear, waiting; output expired).

Verification
REQ-018 add then lw, mem_ready_i always 1 -> states 0,1,2,4 then 0,1,2,3,4; reg_write_o once each; reg_dst_o 01 then 00.
REQ-019 beq with zero_i=1, then bne with zero_i=1 -> pc_write_o with pc_src_o=01 in EXEC only for beq; each returns to FETCH after 3 cycles.
REQ-020 jal -> DECODE cycle shows pc_write_o=1, pc_src_o=10, reg_write_o=1, reg_dst_o=10, mem_to_reg_o=10.
REQ-021 TIMEOUT=4, sw with mem_ready_i held 0 in MEM -> ERR after 4 wait cycles, err_o=1, mem_write_o=0; rst_i pulse -> FETCH, err_o=0.
REQ-022 Opcode 111111 -> ERR from DECODE; rst_i asserted mid-FETCH wait -> next state FETCH with watchdog cleared; with macro, retired_cnt_o equals completed instruction count.
